reg_bus_arbiter: RTL and testbench

- Shares the single control-register bus (address / write_enable / write_data / read_enable / read_data) among N_MASTERS requesters.
- Uses round-robin arbitration and runs one transaction at a time through a 3-state sequencer.
- Returns a one-cycle ack, plus read data, to the granted master.
- Sits between the masters and the controlling register bank that holds the pipe-enable fields.

---
 rtl/reg_bus_pkg.sv | 22 ++
 rtl/reg_bus_arbiter_if.sv | 28 ++
 rtl/reg_bus_arbiter_rr_arbiter.sv | 44 ++++
 rtl/reg_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bus arbiter slice.
package reg_bus_pkg;

    // Sequencer states: one transaction at a time, three cycles each.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default register-bus widths.
    localparam int ADDR_W  = 33;
    localparam int WDATA_W = 33;
    localparam int RDATA_W = 21;

    // Values driven on the bus whenever no access is in flight.
    localparam logic [ADDR_W-1:0]  ADDR_IDLE   = '0;
    localparam logic [WDATA_W-1:0] WDATA_IDLE  = '0;
    localparam logic [RDATA_W-1:0] RDATA_IDLE  = '0;
    localparam logic               STROBE_IDLE = 1'b0;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Control-register bus between the arbiter (master) and the register bank (slave).
interface reg_bus_if #(
    parameter int ADDR_W  = reg_bus_pkg::ADDR_W,
    parameter int WDATA_W = reg_bus_pkg::WDATA_W,
    parameter int RDATA_W = reg_bus_pkg::RDATA_W
) ();
    logic [ADDR_W-1:0]  address;
    logic               write_enable;
    logic [WDATA_W-1:0] write_data;
    logic               read_enable;
    logic [RDATA_W-1:0] read_data;

    modport master (
        output address,
        output write_enable,
        output write_data,
        output read_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_enable,
        input  write_data,
        input  read_enable,
        output read_data
    );
endinterface

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant
// and wraps, using a double-width rotate followed by a priority encoder.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             grant_valid
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

    logic [IDX_W-1:0] start;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    // Explicit wrap so N need not be a power of two.
    assign start   = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
    assign req_dbl = {req, req};

    // Rotate so bit 0 is the highest-priority master, then take the lowest set bit.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // paths that skip an assignment infer a latch.
        rotated     = '0;
        offset      = '0;
        sum         = '0;
        grant_valid = |req;
        for (int i = 0; i < N; i++) begin
            rotated[i] = req_dbl[int'(start) + i];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum   = {1'b0, start} + {1'b0, offset};
        grant = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : IDX_W'(sum);
    end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one control-register bus among N_MASTERS requesters. Round-robin
// grant in IDLE, one bus cycle in ACCESS, one-cycle ack with read data in RESP.
module reg_bus_arbiter #(
    parameter  int N_MASTERS = 4,
    parameter  int ADDR_W    = reg_bus_pkg::ADDR_W,
    parameter  int WDATA_W   = reg_bus_pkg::WDATA_W,
    parameter  int RDATA_W   = reg_bus_pkg::RDATA_W,
    localparam int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         m_req,
    input  logic [N_MASTERS-1:0]         m_we,
    input  logic [N_MASTERS-1:0]         m_re,
    input  logic [N_MASTERS*ADDR_W-1:0]  m_addr,
    input  logic [N_MASTERS*WDATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]         m_ack,
    output logic [RDATA_W-1:0]           m_rdata,
    reg_bus_if.master                    bus,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx
);
    import reg_bus_pkg::*;

    state_t             state, state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WDATA_W-1:0] wdata_q;
    logic               we_q;
    logic               re_q;
    logic [RDATA_W-1:0] rdata_q;
    logic               read_strobe;

    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;

    rr_arbiter #(.N(N_MASTERS)) u_rr_arbiter (
        .req         (m_req),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // A write takes precedence; a read requested alongside it is dropped.
    assign read_strobe = re_q & ~we_q;
    assign grant_idx   = grant_q;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all state-decoded outputs.
    always_comb begin
        state_next        = state;
        m_ack             = '0;
        m_rdata           = RDATA_W'(RDATA_IDLE);
        bus.address       = ADDR_W'(ADDR_IDLE);
        bus.write_data    = WDATA_W'(WDATA_IDLE);
        bus.write_enable  = STROBE_IDLE;
        bus.read_enable   = STROBE_IDLE;
        busy              = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.address      = addr_q;
                bus.write_data   = wdata_q;
                bus.write_enable = we_q;
                bus.read_enable  = read_strobe;
                state_next       = ST_RESP;
            end
            ST_RESP: begin
                m_ack[grant_q] = 1'b1;
                m_rdata        = rdata_q;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Transaction capture, read-data sampling and round-robin pointer update.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: the capture registers are reset too, so grant_idx and every
        // bus field read back as zero straight out of reset.
        if (!reset) begin
            last_grant <= IDX_W'(N_MASTERS - 1);
            grant_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        addr_q  <= m_addr[int'(arb_grant)*ADDR_W +: ADDR_W];
                        wdata_q <= m_wdata[int'(arb_grant)*WDATA_W +: WDATA_W];
                        we_q    <= m_we[arb_grant];
                        re_q    <= m_re[arb_grant];
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= read_strobe ? bus.read_data : RDATA_W'(RDATA_IDLE);
                end
                ST_RESP: begin
                    last_grant <= grant_q;
                end
                default: begin
                    last_grant <= last_grant;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: inputs change on the falling edge,
// outputs are compared on the falling edge (or just after an async reset).
module tb_reg_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 33;
    localparam int WW = 33;
    localparam int RW = 21;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we  = '0;
    logic [N-1:0]    m_re  = '0;
    logic [N*AW-1:0] m_addr  = '0;
    logic [N*WW-1:0] m_wdata = '0;
    logic [N-1:0]    m_ack;
    logic [RW-1:0]   m_rdata;
    logic            busy;
    logic [1:0]      grant_idx;
    logic [RW-1:0]   rd_val = '0;

    int vectors    = 0;
    int miscompares = 0;

    reg_bus_if #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) bus ();
    assign bus.read_data = rd_val;

    reg_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) dut (
        .clock     (clock),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_re      (m_re),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clock = ~clock;

    task automatic set_master(input int i, input logic req, input logic we, input logic re,
                              input logic [AW-1:0] addr, input logic [WW-1:0] wdata);
        m_req[i] = req;
        m_we[i]  = we;
        m_re[i]  = re;
        m_addr[i*AW +: AW]  = addr;
        m_wdata[i*WW +: WW] = wdata;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        reset = 1'b0;
        #12;
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0);
        end
        vectors++;
        if ({bus.address, bus.write_data, m_rdata, grant_idx} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h grant %0d expected all 0",
                     bus.address, bus.write_data, m_rdata, grant_idx);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_write_m1();
        logic [6:0] ctl;
        @(negedge clock);
        set_master(1, 1'b1, 1'b1, 1'b0, 33'hAA, 33'h1234);
        @(negedge clock);  // ACCESS
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b1_0_1_0000) begin
            miscompares++;
            $display("FAIL wr_access_ctl: got %b expected %b", ctl, 7'b1010000);
        end
        vectors++;
        if (bus.address !== 33'hAA || bus.write_data !== 33'h1234 || grant_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL wr_access_bus: addr %h wdata %h grant %0d expected aa 1234 1",
                     bus.address, bus.write_data, grant_idx);
        end
        @(negedge clock);  // RESP
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0_0_1_0010) begin
            miscompares++;
            $display("FAIL wr_resp_ctl: got %b expected %b", ctl, 7'b0010010);
        end
        vectors++;
        if (bus.address !== 33'h0) begin
            miscompares++;
            $display("FAIL wr_resp_addr: got %h expected 0", bus.address);
        end
        set_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);  // IDLE
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0) begin
            miscompares++;
            $display("FAIL wr_idle_ctl: got %b expected %b", ctl, 7'b0);
        end
    endtask

    task automatic test_read_m2();
        logic [6:0] ctl;
        rd_val = 21'h1;
        set_master(2, 1'b1, 1'b0, 1'b1, 33'h55, '0);
        @(negedge clock);  // ACCESS
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0_1_1_0000 || bus.address !== 33'h55 || grant_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL rd_access: ctl %b addr %h grant %0d expected 0110000 55 2",
                     ctl, bus.address, grant_idx);
        end
        @(negedge clock);  // RESP
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0_0_1_0100 || m_rdata !== 21'h1) begin
            miscompares++;
            $display("FAIL rd_resp: ctl %b rdata %h expected 0010100 1", ctl, m_rdata);
        end
        set_master(2, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);  // IDLE
        vectors++;
        if (m_rdata !== 21'h0 || m_ack !== 4'b0) begin
            miscompares++;
            $display("FAIL rd_after: rdata %h ack %b expected 0 0000", m_rdata, m_ack);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx;
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            set_master(i, 1'b1, 1'b1, 1'b0, AW'(33'h100 + i), WW'(i));
        end
        for (int k = 0; k < 12; k++) begin
            exp_idx = k % N;
            @(negedge clock);  // ACCESS
            vectors++;
            if (grant_idx !== 2'(exp_idx) || bus.address !== AW'(33'h100 + exp_idx)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: grant %0d addr %h expected %0d %h",
                         k, grant_idx, bus.address, exp_idx, 33'h100 + exp_idx);
            end
            @(negedge clock);  // RESP
            vectors++;
            if (m_ack !== 4'(1 << exp_idx)) begin
                miscompares++;
                $display("FAIL rr_ack_%0d: got %b expected %b", k, m_ack, 4'(1 << exp_idx));
            end
            @(negedge clock);  // IDLE: acks are exactly three cycles apart
            vectors++;
            if (m_ack !== 4'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_gap_%0d: ack %b busy %b expected 0000 0", k, m_ack, busy);
            end
            if (k == 11) begin
                m_req = '0;
            end
        end
    endtask

    task automatic test_we_re_conflict();
        logic [6:0] ctl;
        rd_val = 21'h15A5A;
        set_master(0, 1'b1, 1'b1, 1'b1, 33'h10, 33'hBEEF);
        @(negedge clock);  // ACCESS
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b1_0_1_0000 || grant_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL both_access: ctl %b grant %0d expected 1010000 0", ctl, grant_idx);
        end
        @(negedge clock);  // RESP
        vectors++;
        if (m_ack !== 4'b0001 || m_rdata !== 21'h0) begin
            miscompares++;
            $display("FAIL both_resp: ack %b rdata %h expected 0001 0", m_ack, m_rdata);
        end
        set_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_master(3, 1'b1, 1'b0, 1'b0, 33'h20, 33'h0);
        @(negedge clock);  // IDLE
        @(negedge clock);  // ACCESS
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0_0_1_0000 || grant_idx !== 2'd3) begin
            miscompares++;
            $display("FAIL none_access: ctl %b grant %0d expected 0010000 3", ctl, grant_idx);
        end
        @(negedge clock);  // RESP
        vectors++;
        if (m_ack !== 4'b1000 || m_rdata !== 21'h0) begin
            miscompares++;
            $display("FAIL none_resp: ack %b rdata %h expected 1000 0", m_ack, m_rdata);
        end
        set_master(3, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);  // IDLE
    endtask

    task automatic test_drop_after_grant();
        set_master(1, 1'b1, 1'b1, 1'b0, 33'h1_0000_0001, 33'h0_CAFE_0001);
        @(posedge clock);
        #1;
        set_master(1, 1'b0, 1'b1, 1'b0, 33'h0_0000_0BAD, 33'h0_0000_0BAD);
        @(negedge clock);  // ACCESS
        vectors++;
        if (bus.address !== 33'h1_0000_0001 || bus.write_data !== 33'h0_CAFE_0001 ||
            bus.write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_access: addr %h wdata %h we %b expected 100000001 0cafe0001 1",
                     bus.address, bus.write_data, bus.write_enable);
        end
        @(negedge clock);  // RESP
        vectors++;
        if (m_ack !== 4'b0010) begin
            miscompares++;
            $display("FAIL drop_ack: got %b expected 0010", m_ack);
        end
        @(negedge clock);  // IDLE
    endtask

    task automatic test_reset_mid();
        logic [6:0] ctl;
        set_master(1, 1'b1, 1'b1, 1'b0, 33'h77, 33'h77);
        @(negedge clock);  // ACCESS
        vectors++;
        if (bus.write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: we %b expected 1", bus.write_enable);
        end
        reset = 1'b0;
        #1;
        ctl = {bus.write_enable, bus.read_enable, busy, m_ack};
        vectors++;
        if (ctl !== 7'b0 || grant_idx !== 2'd0 || bus.address !== 33'h0) begin
            miscompares++;
            $display("FAIL rstmid_abort: ctl %b grant %0d addr %h expected 0000000 0 0",
                     ctl, grant_idx, bus.address);
        end
        set_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_master(0, 1'b1, 1'b1, 1'b0, 33'hA0, 33'h1);
        set_master(2, 1'b1, 1'b1, 1'b0, 33'hA2, 33'h2);
        @(negedge clock);
        vectors++;
        if (m_ack !== 4'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_noack: ack %b busy %b expected 0000 0", m_ack, busy);
        end
        reset = 1'b1;
        @(negedge clock);  // ACCESS
        vectors++;
        if (grant_idx !== 2'd0 || bus.address !== 33'hA0) begin
            miscompares++;
            $display("FAIL rstmid_first: grant %0d addr %h expected 0 a0", grant_idx, bus.address);
        end
        @(negedge clock);  // RESP
        vectors++;
        if (m_ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_ack0: got %b expected 0001", m_ack);
        end
        set_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);  // IDLE
        @(negedge clock);  // ACCESS
        vectors++;
        if (grant_idx !== 2'd2 || bus.address !== 33'hA2) begin
            miscompares++;
            $display("FAIL rstmid_second: grant %0d addr %h expected 2 a2", grant_idx, bus.address);
        end
        @(negedge clock);  // RESP
        vectors++;
        if (m_ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL rstmid_ack2: got %b expected 0100", m_ack);
        end
        set_master(2, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_write_m1();
        test_read_m2();
        test_round_robin();
        test_we_re_conflict();
        test_drop_after_grant();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
